// File: rtl/alu_mc_if.sv
// Request/result bus of the multi-cycle ALU.
// A request transfers on a rising clk edge where in_valid && in_ready; a result transfers where out_valid && out_ready, and out_valid/out_data/out_err hold until then.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_A;
    logic [WIDTH-1:0]     in_B;
    logic [3:0]           mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_data;
    logic                 out_err;

    modport master (
        output in_valid, in_A, in_B, mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_A, in_B, mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle WIDTH-bit integer ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, one operation in flight at a time.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_mc_if.slave     bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic                 pend;
    logic [WIDTH-1:0]     a_r, b_r, opb;
    logic [3:0]           mode_r;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   prod, prod_nx, iter_result, quick_data;
    logic [2*WIDTH-1:0]   data_r;
    logic                 err_r, quick_err;
    logic                 accept, iter_op, is_div, signed_op, neg_q, neg_r, ovf, last_iter;
    logic [WIDTH-1:0]     mag_a, mag_b, q_mag, r_mag;
    logic [WIDTH:0]       add_s, sub_s, mul_sum, div_sh;
    logic                 div_ge;

    function automatic logic [2*WIDTH-1:0] sat_ext(input logic [WIDTH:0] s);
        logic [WIDTH-1:0] v;
        if (s[WIDTH] != s[WIDTH-1])
            v = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            v = s[WIDTH-1:0];
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // A request is held in a_r/b_r/mode_r for one cycle (pend) before the FSM dispatches it.
    assign bus.in_ready  = rst_n && (state == S_IDLE) && !pend;
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_data  = data_r;
    assign bus.out_err   = err_r;
    assign dbg_state     = state;

    assign accept    = bus.in_valid && bus.in_ready;
    assign is_div    = (mode_r == 4'd10) || (mode_r == 4'd12);
    assign signed_op = (mode_r == 4'd11) || (mode_r == 4'd12);
    assign iter_op   = (mode_r == 4'd9) || (mode_r == 4'd11) || (is_div && (b_r != '0));
    assign neg_q     = signed_op && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    assign neg_r     = signed_op && a_r[WIDTH-1];
    assign ovf       = (mode_r == 4'd12) && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == '1);
    assign mag_a     = (signed_op && a_r[WIDTH-1]) ? -a_r : a_r;
    assign mag_b     = (signed_op && b_r[WIDTH-1]) ? -b_r : b_r;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pend) state_nx = iter_op ? S_ITER : S_DONE;
            S_ITER:  if (last_iter) state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        quick_data = '0;
        quick_err  = 1'b0;
        add_s = {a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r};
        sub_s = {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r};
        case (mode_r)
            4'd0: begin quick_data = sat_ext(add_s); quick_err = add_s[WIDTH] != add_s[WIDTH-1]; end
            4'd1: begin quick_data = sat_ext(sub_s); quick_err = sub_s[WIDTH] != sub_s[WIDTH-1]; end
            4'd2: quick_data = {{WIDTH{1'b0}}, a_r & b_r};
            4'd3: quick_data = {{WIDTH{1'b0}}, a_r | b_r};
            4'd4: quick_data = {{WIDTH{1'b0}}, a_r ^ b_r};
            4'd5: quick_data = {{(2*WIDTH-1){1'b0}}, a_r == b_r};
            4'd6: quick_data = {{(2*WIDTH-1){1'b0}}, $signed(a_r) >= $signed(b_r)};
            4'd7: quick_data = (b_r >= WIDTH'(WIDTH)) ? '0 : {{WIDTH{1'b0}}, a_r >> b_r};
            4'd8: quick_data = (b_r >= WIDTH'(WIDTH)) ? '0 : {{WIDTH{1'b0}}, a_r << b_r};
            4'd10, 4'd12: begin quick_data = {a_r, {WIDTH{1'b1}}}; quick_err = 1'b1; end
            4'd13, 4'd14, 4'd15: quick_err = 1'b1;
            default: quick_data = '0;
        endcase
    end

    // prod holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : '0);
        div_sh  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opb};
        if (is_div)
            prod_nx = {(div_ge ? (div_sh[WIDTH-1:0] - opb) : div_sh[WIDTH-1:0]),
                       prod[WIDTH-2:0], div_ge};
        else
            prod_nx = {mul_sum, prod[WIDTH-1:1]};
        q_mag = prod_nx[WIDTH-1:0];
        r_mag = prod_nx[2*WIDTH-1:WIDTH];
        if (is_div)
            iter_result = {(neg_r ? -r_mag : r_mag), (neg_q ? -q_mag : q_mag)};
        else
            iter_result = neg_q ? -prod_nx : prod_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= '0;
            opb    <= '0;
            prod   <= '0;
            cnt    <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if (accept) begin
                a_r    <= bus.in_A;
                b_r    <= bus.in_B;
                mode_r <= bus.mode;
                pend   <= 1'b1;
            end
            case (state)
                S_IDLE: if (pend) begin
                    pend <= 1'b0;
                    cnt  <= '0;
                    if (iter_op) begin
                        prod <= {{WIDTH{1'b0}}, mag_a};
                        opb  <= mag_b;
                    end else begin
                        data_r <= quick_data;
                        err_r  <= quick_err;
                    end
                end
                S_ITER: begin
                    prod <= prod_nx;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        data_r <= iter_result;
                        err_r  <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: 32-bit and 8-bit instances, directed cases and
// random operations compared against an arithmetic reference model.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] dbg32, dbg8;
    int checks = 0;
    int failures = 0;
    logic [128:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus32();
    alu_mc_if #(.WIDTH(8))  bus8();

    alu_mc #(.WIDTH(32)) u_alu32 (.clk(clk), .rst_n(rst_n), .bus(bus32), .dbg_state(dbg32));
    alu_mc #(.WIDTH(8))  u_alu8  (.clk(clk), .rst_n(rst_n), .bus(bus8),  .dbg_state(dbg8));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {err, data} from plain signed/unsigned arithmetic at width w.
    function automatic logic [128:0] ref_model(input int w, input logic [3:0] m,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, uq, ur;
        logic [127:0] mask2, d;
        logic e;
        longint sa, sb, r, mn, mx, q, rm;
        mask  = (64'd1 << w) - 64'd1;
        mask2 = (128'd1 << (2 * w)) - 128'd1;
        sa = longint'(a & mask);
        if (a[w-1]) sa -= (longint'(1) << w);
        sb = longint'(b & mask);
        if (b[w-1]) sb -= (longint'(1) << w);
        mn = -(longint'(1) << (w - 1));
        mx = (longint'(1) << (w - 1)) - 1;
        d = '0;
        e = 1'b0;
        case (m)
            4'd0, 4'd1: begin
                r = (m == 4'd0) ? sa + sb : sa - sb;
                if (r > mx) begin r = mx; e = 1'b1; end
                else if (r < mn) begin r = mn; e = 1'b1; end
                d = {{64{r[63]}}, r} & mask2;
            end
            4'd2: d = 128'(a & b);
            4'd3: d = 128'(a | b);
            4'd4: d = 128'(a ^ b);
            4'd5: d = 128'(a == b);
            4'd6: d = 128'(sa >= sb);
            4'd7: d = (b >= 64'(w)) ? '0 : 128'(a >> b);
            4'd8: d = (b >= 64'(w)) ? '0 : 128'((a << b) & mask);
            4'd9: d = 128'(a) * 128'(b);
            4'd10, 4'd12: begin
                if (b == 64'd0) begin
                    d = (128'(a) << w) | 128'(mask);
                    e = 1'b1;
                end else if (m == 4'd10) begin
                    uq = a / b;
                    ur = a % b;
                    d = (128'(ur) << w) | 128'(uq);
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    e  = (sa == mn) && (sb == -1);
                    d  = (128'(64'(rm) & mask) << w) | 128'(64'(q) & mask);
                end
            end
            4'd11: begin
                r = sa * sb;
                d = {{64{r[63]}}, r} & mask2;
            end
            default: e = 1'b1;
        endcase
        return {e, d};
    endfunction

    function automatic bit is_iter(input logic [3:0] m, input logic [63:0] b);
        return (m == 4'd9) || (m == 4'd11) || (((m == 4'd10) || (m == 4'd12)) && (b != 64'd0));
    endfunction

    task automatic drive(input int w, input logic v, input logic [3:0] m,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            bus32.in_valid = v; bus32.mode = m; bus32.in_A = a[31:0]; bus32.in_B = b[31:0];
        end else begin
            bus8.in_valid = v; bus8.mode = m; bus8.in_A = a[7:0]; bus8.in_B = b[7:0];
        end
    endtask

    task automatic set_oready(input int w, input logic v);
        if (w == 32) bus32.out_ready = v;
        else         bus8.out_ready = v;
    endtask

    // {in_ready, out_valid, out_err, out_data}
    function automatic logic [130:0] sample(input int w);
        if (w == 32)
            return {bus32.in_ready, bus32.out_valid, bus32.out_err, 64'd0, bus32.out_data};
        return {bus8.in_ready, bus8.out_valid, bus8.out_err, 112'd0, bus8.out_data};
    endfunction

    task automatic run_op(input int w, input logic [3:0] m, input logic [63:0] a,
                          input logic [63:0] b, input int hold, output logic [127:0] got);
        logic [63:0] mask, am, bm;
        logic [128:0] ex;
        logic [130:0] s;
        int n, exp_lat;
        mask = (64'd1 << w) - 64'd1;
        am = a & mask;
        bm = b & mask;
        exp_q.push_back(ref_model(w, m, am, bm));
        exp_lat = is_iter(m, bm) ? w + 1 : 1;
        n = 0;
        s = sample(w);
        while (!s[130] && n < 200) begin @(posedge clk); #1; n++; s = sample(w); end
        chk("in_ready_idle", 128'(s[130]), 128'd1);
        drive(w, 1'b1, m, am, bm);
        @(posedge clk); #1;
        drive(w, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        s = sample(w);
        chk("in_ready_after_accept", 128'(s[130]), 128'd0);
        n = 0;
        while (!s[129] && n < 200) begin @(posedge clk); #1; n++; s = sample(w); end
        chk("latency", 128'(n), 128'(exp_lat));
        ex = exp_q.pop_front();
        chk("out_data", s[127:0], ex[127:0]);
        chk("out_err", 128'(s[128]), 128'(ex[128]));
        got = s[127:0];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            s = sample(w);
            chk("hold_valid", 128'(s[129]), 128'd1);
            chk("hold_data", s[127:0], ex[127:0]);
            chk("hold_err", 128'(s[128]), 128'(ex[128]));
            chk("hold_in_ready", 128'(s[130]), 128'd0);
        end
        set_oready(w, 1'b1);
        @(posedge clk); #1;
        set_oready(w, 1'b0);
        s = sample(w);
        chk("valid_dropped", 128'(s[129]), 128'd0);
        chk("in_ready_back", 128'(s[130]), 128'd1);
    endtask

    function automatic logic [63:0] pick(input int w);
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'($urandom_range(0, 40));
            2: return '1;
            3: return 64'd1 << (w - 1);
            4: return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [127:0] got;
        logic [130:0] s;
        rst_n = 1'b0;
        drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
        drive(8, 1'b0, 4'd0, 64'd0, 64'd0);
        set_oready(32, 1'b0);
        set_oready(8, 1'b0);
        #1;
        s = sample(32);
        chk("reset_in_ready", 128'(s[130]), 128'd0);
        chk("reset_out_valid", 128'(s[129]), 128'd0);
        chk("reset_out_data", s[127:0], 128'd0);
        chk("reset_out_err", 128'(s[128]), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 s = sample(32);
        chk("release_in_ready", 128'(s[130]), 128'd1);

        run_op(32, 4'd0, 64'h7FFFFFF0, 64'h20, 0, got);
        chk("tp_add_sat", got, 128'h7FFFFFFF);
        run_op(32, 4'd0, 64'd5, 64'hFFFFFFFD, 0, got);
        chk("tp_add_small", got, 128'd2);
        run_op(32, 4'd1, 64'h80000000, 64'd1, 0, got);
        run_op(32, 4'd9, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, got);
        chk("tp_mul_max", got, 128'hFFFFFFFE00000001);
        run_op(32, 4'd12, 64'hFFFFFFF9, 64'd2, 0, got);
        chk("tp_sdiv", got, 128'hFFFFFFFF_FFFFFFFD);
        run_op(32, 4'd10, 64'd100, 64'd0, 0, got);
        chk("tp_div0", got, 128'h00000064_FFFFFFFF);
        run_op(32, 4'd12, 64'h80000000, 64'hFFFFFFFF, 0, got);
        run_op(32, 4'd7, 64'hDEADBEEF, 64'd32, 0, got);
        run_op(32, 4'd8, 64'h00000003, 64'd31, 0, got);
        run_op(32, 4'd14, 64'h1234, 64'h5678, 0, got);
        run_op(32, 4'd11, 64'hFFFFFFFD, 64'd4, 5, got);
        chk("tp_smul", got, 128'hFFFFFFFFFFFFFFF4);

        // Abort a divide mid-iteration; the previous result is still on out_data.
        drive(32, 1'b1, 4'd10, 64'd1000, 64'd7);
        @(posedge clk); #1;
        drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 s = sample(32);
        chk("abort_out_valid", 128'(s[129]), 128'd0);
        chk("abort_out_data", s[127:0], 128'd0);
        chk("abort_out_err", 128'(s[128]), 128'd0);
        chk("abort_in_ready", 128'(s[130]), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 s = sample(32);
        chk("abort_release_ready", 128'(s[130]), 128'd1);
        repeat (40) @(posedge clk);
        #1 s = sample(32);
        chk("abort_no_result", 128'(s[129]), 128'd0);
        run_op(32, 4'd2, 64'hF0F0, 64'hFF00, 0, got);
        chk("tp_and", got, 128'hF000);

        for (int i = 0; i < 40; i++)
            run_op(32, 4'($urandom_range(0, 15)), pick(32), pick(32), $urandom_range(0, 2), got);

        run_op(8, 4'd9, 64'hFF, 64'h02, 0, got);
        chk("tp8_mul", got, 128'h01FE);
        run_op(8, 4'd7, 64'hA5, 64'd8, 0, got);
        chk("tp8_shr_wide", got, 128'd0);
        run_op(8, 4'd12, 64'h80, 64'hFF, 1, got);
        for (int i = 0; i < 30; i++)
            run_op(8, 4'($urandom_range(0, 15)), pick(8), pick(8), $urandom_range(0, 2), got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
